// File: rtl/bram_wr_arbiter.sv
// Two-requester write arbiter for a 16-bank history buffer: lane k with row
// select r writes bank 4*r+k; overlapping requests alternate via a priority bit.
module bram_wr_arbiter (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [63:0]     a_data0,
    input  logic [63:0]     a_data1,
    input  logic [63:0]     a_data2,
    input  logic [63:0]     a_data3,
    input  logic [8:0]      a_addr0,
    input  logic [8:0]      a_addr1,
    input  logic [8:0]      a_addr2,
    input  logic [8:0]      a_addr3,
    input  logic [8:0]      a_wr0,
    input  logic [8:0]      a_wr1,
    input  logic [8:0]      a_wr2,
    input  logic [8:0]      a_wr3,
    input  logic [3:0]      a_sel0,
    input  logic [3:0]      a_sel1,
    input  logic [3:0]      a_sel2,
    input  logic [3:0]      a_sel3,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [63:0]     b_data0,
    input  logic [63:0]     b_data1,
    input  logic [63:0]     b_data2,
    input  logic [63:0]     b_data3,
    input  logic [8:0]      b_addr0,
    input  logic [8:0]      b_addr1,
    input  logic [8:0]      b_addr2,
    input  logic [8:0]      b_addr3,
    input  logic [8:0]      b_wr0,
    input  logic [8:0]      b_wr1,
    input  logic [8:0]      b_wr2,
    input  logic [8:0]      b_wr3,
    input  logic [3:0]      b_sel0,
    input  logic [3:0]      b_sel1,
    input  logic [3:0]      b_sel2,
    input  logic [3:0]      b_sel3,
    output logic [127:0]    bank_we,
    output logic [143:0]    bank_addr,
    output logic [1023:0]   bank_data,
    output logic [15:0]     conflict_cnt,
    output logic            sel_err
);
    logic [63:0] w_a_data [4];
    logic [63:0] w_b_data [4];
    logic [8:0]  w_a_addr [4];
    logic [8:0]  w_b_addr [4];
    logic [8:0]  w_a_wr   [4];
    logic [8:0]  w_b_wr   [4];
    logic [3:0]  w_a_sel  [4];
    logic [3:0]  w_b_sel  [4];

    logic [3:0]  w_a_oh, w_b_oh, w_a_bad, w_b_bad;
    logic [15:0] w_mask_a, w_mask_b;
    logic        w_conflict;
    logic        r_prio;
    logic [15:0] r_cnt;
    logic        r_sel_err;

    assign w_a_data = '{a_data0, a_data1, a_data2, a_data3};
    assign w_b_data = '{b_data0, b_data1, b_data2, b_data3};
    assign w_a_addr = '{a_addr0, a_addr1, a_addr2, a_addr3};
    assign w_b_addr = '{b_addr0, b_addr1, b_addr2, b_addr3};
    assign w_a_wr   = '{a_wr0, a_wr1, a_wr2, a_wr3};
    assign w_b_wr   = '{b_wr0, b_wr1, b_wr2, b_wr3};
    assign w_a_sel  = '{a_sel0, a_sel1, a_sel2, a_sel3};
    assign w_b_sel  = '{b_sel0, b_sel1, b_sel2, b_sel3};

    function automatic logic f_onehot(input logic [3:0] s);
        return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_a_oh[k]  = f_onehot(w_a_sel[k]);
        assign w_b_oh[k]  = f_onehot(w_b_sel[k]);
        assign w_a_bad[k] = w_a_wr[k][8] & ~w_a_oh[k];
        assign w_b_bad[k] = w_b_wr[k][8] & ~w_b_oh[k];
    end

    // Bank g is reachable only from lane g%4 through row g/4, so masks decode per bank.
    for (genvar g = 0; g < 16; g++) begin : g_mask
        assign w_mask_a[g] = a_valid & w_a_wr[g%4][8] & w_a_oh[g%4] & w_a_sel[g%4][g/4];
        assign w_mask_b[g] = b_valid & w_b_wr[g%4][8] & w_b_oh[g%4] & w_b_sel[g%4][g/4];
    end

    assign w_conflict = a_valid & b_valid & (|(w_mask_a & w_mask_b));
    assign a_ready    = a_valid & ~(w_conflict & r_prio);
    assign b_ready    = b_valid & ~(w_conflict & ~r_prio);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_cnt     <= 16'd0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_conflict) begin
                r_prio <= ~r_prio;
                if (r_cnt != 16'hFFFF)
                    r_cnt <= r_cnt + 16'd1;
            end
            if ((a_ready & (|w_a_bad)) | (b_ready & (|w_b_bad)))
                r_sel_err <= 1'b1;
        end
    end

    assign conflict_cnt = r_cnt;
    assign sel_err      = r_sel_err;

    // Granted masks never overlap, so at most one requester writes a given bank.
    for (genvar g = 0; g < 16; g++) begin : g_bank
        logic [7:0]  r_we;
        logic [8:0]  r_addr;
        logic [63:0] r_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_we   <= 8'd0;
                r_addr <= 9'd0;
                r_data <= 64'd0;
            end else if (a_ready && w_mask_a[g]) begin
                r_we   <= w_a_wr[g%4][7:0];
                r_addr <= w_a_addr[g%4];
                r_data <= w_a_data[g%4];
            end else if (b_ready && w_mask_b[g]) begin
                r_we   <= w_b_wr[g%4][7:0];
                r_addr <= w_b_addr[g%4];
                r_data <= w_b_data[g%4];
            end else begin
                r_we   <= 8'd0;
            end
        end

        assign bank_we[8*g +: 8]    = r_we;
        assign bank_addr[9*g +: 9]  = r_addr;
        assign bank_data[64*g +: 64] = r_data;
    end
endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Directed bench for bram_wr_arbiter: expected bank images are queued when a
// command is driven and compared one clock later when the outputs update.
module tb_bram_wr_arbiter;
    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid, a_ready, b_ready;
    logic [63:0]     a_d [4];
    logic [63:0]     b_d [4];
    logic [8:0]      a_ad [4];
    logic [8:0]      b_ad [4];
    logic [8:0]      a_w [4];
    logic [8:0]      b_w [4];
    logic [3:0]      a_s [4];
    logic [3:0]      b_s [4];
    logic [127:0]    bank_we;
    logic [143:0]    bank_addr;
    logic [1023:0]   bank_data;
    logic [15:0]     conflict_cnt;
    logic            sel_err;

    typedef struct {
        logic [127:0]  we;
        logic [143:0]  addr;
        logic [1023:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [8:0]  m_addr [16];
    logic [63:0] m_data [16];
    logic [127:0] e_we;
    int          n_assert;
    int          n_fail;

    always #5 clk = ~clk;

    bram_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_data0(a_d[0]), .a_data1(a_d[1]), .a_data2(a_d[2]), .a_data3(a_d[3]),
        .a_addr0(a_ad[0]), .a_addr1(a_ad[1]), .a_addr2(a_ad[2]), .a_addr3(a_ad[3]),
        .a_wr0(a_w[0]), .a_wr1(a_w[1]), .a_wr2(a_w[2]), .a_wr3(a_w[3]),
        .a_sel0(a_s[0]), .a_sel1(a_s[1]), .a_sel2(a_s[2]), .a_sel3(a_s[3]),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_data0(b_d[0]), .b_data1(b_d[1]), .b_data2(b_d[2]), .b_data3(b_d[3]),
        .b_addr0(b_ad[0]), .b_addr1(b_ad[1]), .b_addr2(b_ad[2]), .b_addr3(b_ad[3]),
        .b_wr0(b_w[0]), .b_wr1(b_w[1]), .b_wr2(b_w[2]), .b_wr3(b_w[3]),
        .b_sel0(b_s[0]), .b_sel1(b_s[1]), .b_sel2(b_s[2]), .b_sel3(b_s[3]),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_data(bank_data),
        .conflict_cnt(conflict_cnt), .sel_err(sel_err)
    );

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr();
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_d[k] = '0; a_ad[k] = '0; a_w[k] = '0; a_s[k] = '0;
            b_d[k] = '0; b_ad[k] = '0; b_w[k] = '0; b_s[k] = '0;
        end
    endtask

    task automatic drv();
        @(negedge clk);
        clr();
    endtask

    task automatic lane_a(input int k, input logic [8:0] w, input logic [3:0] s,
                          input logic [8:0] ad, input logic [63:0] d);
        a_w[k] = w; a_s[k] = s; a_ad[k] = ad; a_d[k] = d;
    endtask

    task automatic lane_b(input int k, input logic [8:0] w, input logic [3:0] s,
                          input logic [8:0] ad, input logic [63:0] d);
        b_w[k] = w; b_s[k] = s; b_ad[k] = ad; b_d[k] = d;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 16; b++) begin
            m_addr[b] = '0;
            m_data[b] = '0;
        end
        e_we = '0;
    endtask

    task automatic exp_wr(input int b, input logic [7:0] we, input logic [8:0] ad, input logic [63:0] d);
        e_we[8*b +: 8] = we;
        m_addr[b] = ad;
        m_data[b] = d;
    endtask

    function automatic exp_t mk_exp();
        exp_t e;
        e.we = e_we;
        for (int b = 0; b < 16; b++) begin
            e.addr[9*b +: 9]   = m_addr[b];
            e.data[64*b +: 64] = m_data[b];
        end
        return e;
    endfunction

    task automatic exp_push();
        sb.push_back(mk_exp());
        e_we = '0;
    endtask

    task automatic chk_exp(input string tag, input exp_t e);
        chk({tag, "_we"}, 144'(bank_we), 144'(e.we));
        chk({tag, "_addr"}, bank_addr, e.addr);
        for (int b = 0; b < 16; b++)
            chk($sformatf("%s_data%0d", tag, b), 144'(bank_data[64*b +: 64]), 144'(e.data[64*b +: 64]));
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1 entries", tag);
        end else begin
            e = sb.pop_front();
            chk_exp(tag, e);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        clr();
        model_reset();

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_exp("reset", mk_exp());
        chk("reset_cnt", 144'(conflict_cnt), 144'(16'd0));
        chk("reset_selerr", 144'(sel_err), 144'(1'b0));
        chk("reset_ardy", 144'(a_ready), 144'(1'b0));
        chk("reset_brdy", 144'(b_ready), 144'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        // A only, lane0 row1 -> bank 4
        drv();
        lane_a(0, 9'h1FF, 4'b0010, 9'd5, 64'hDEAD);
        a_valid = 1'b1;
        #1;
        chk("a_only_ardy", 144'(a_ready), 144'(1'b1));
        chk("a_only_brdy", 144'(b_ready), 144'(1'b0));
        exp_wr(4, 8'hFF, 9'd5, 64'hDEAD);
        exp_push();
        tick_check("a_only");

        // disjoint merge: A bank 0, B lane1 bank 1
        drv();
        lane_a(0, 9'h1FF, 4'b0001, 9'd7, 64'h1111);
        lane_b(1, 9'h10F, 4'b0001, 9'd9, 64'h2222);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("merge_ardy", 144'(a_ready), 144'(1'b1));
        chk("merge_brdy", 144'(b_ready), 144'(1'b1));
        exp_wr(0, 8'hFF, 9'd7, 64'h1111);
        exp_wr(1, 8'h0F, 9'd9, 64'h2222);
        exp_push();
        tick_check("merge");
        chk("merge_cnt", 144'(conflict_cnt), 144'(16'd0));

        // B only, lane3 row3 -> bank 15
        drv();
        lane_b(3, 9'h1AA, 4'b1000, 9'd3, 64'h3333);
        b_valid = 1'b1;
        #1;
        chk("b_only_ardy", 144'(a_ready), 144'(1'b0));
        chk("b_only_brdy", 144'(b_ready), 144'(1'b1));
        exp_wr(15, 8'hAA, 9'd3, 64'h3333);
        exp_push();
        tick_check("b_only");

        // three conflict cycles on bank 0: A, B, A
        drv();
        lane_a(0, 9'h1FF, 4'b0001, 9'd1, 64'hA0);
        lane_b(0, 9'h1FF, 4'b0001, 9'd2, 64'hB0);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("cf1_ardy", 144'(a_ready), 144'(1'b1));
        chk("cf1_brdy", 144'(b_ready), 144'(1'b0));
        exp_wr(0, 8'hFF, 9'd1, 64'hA0);
        exp_push();
        tick_check("cf1");

        drv();
        lane_a(0, 9'h1FF, 4'b0001, 9'd11, 64'hA1);
        lane_b(0, 9'h1FF, 4'b0001, 9'd2, 64'hB0);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("cf2_ardy", 144'(a_ready), 144'(1'b0));
        chk("cf2_brdy", 144'(b_ready), 144'(1'b1));
        exp_wr(0, 8'hFF, 9'd2, 64'hB0);
        exp_push();
        tick_check("cf2");

        drv();
        lane_a(0, 9'h1FF, 4'b0001, 9'd11, 64'hA1);
        lane_b(0, 9'h1FF, 4'b0001, 9'd12, 64'hB1);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("cf3_ardy", 144'(a_ready), 144'(1'b1));
        chk("cf3_brdy", 144'(b_ready), 144'(1'b0));
        exp_wr(0, 8'hFF, 9'd11, 64'hA1);
        exp_push();
        tick_check("cf3");
        chk("cf_cnt", 144'(conflict_cnt), 144'(16'd3));

        // non-one-hot select drops lane 1; lane 2 still writes bank 2
        drv();
        lane_a(1, 9'h1FF, 4'b0110, 9'd4, 64'h5555);
        lane_a(2, 9'h1F0, 4'b0001, 9'd6, 64'h6666);
        a_valid = 1'b1;
        #1;
        chk("selerr_ardy", 144'(a_ready), 144'(1'b1));
        exp_wr(2, 8'hF0, 9'd6, 64'h6666);
        exp_push();
        tick_check("selerr");
        chk("selerr_flag", 144'(sel_err), 144'(1'b1));

        // both valid with empty masks: both accepted, nothing written
        drv();
        lane_a(0, 9'h0FF, 4'b0001, 9'd13, 64'h9999);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("empty_ardy", 144'(a_ready), 144'(1'b1));
        chk("empty_brdy", 144'(b_ready), 144'(1'b1));
        exp_push();
        tick_check("empty");
        chk("empty_selerr", 144'(sel_err), 144'(1'b1));
        chk("empty_cnt", 144'(conflict_cnt), 144'(16'd3));

        // asynchronous reset between edges while A is valid
        drv();
        lane_a(0, 9'h1FF, 4'b0001, 9'd8, 64'h7777);
        a_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_exp("async_rst", mk_exp());
        chk("async_rst_cnt", 144'(conflict_cnt), 144'(16'd0));
        chk("async_rst_selerr", 144'(sel_err), 144'(1'b0));
        chk("async_rst_ardy", 144'(a_ready), 144'(1'b1));
        @(posedge clk);
        #1;
        chk("rst_edge_we", 144'(bank_we), 144'(128'd0));
        @(negedge clk);
        rst = 1'b0;
        clr();
        exp_push();
        tick_check("post_rst");

        // priority restarts at A after reset
        drv();
        lane_a(0, 9'h1FF, 4'b0001, 9'd20, 64'hAAAA);
        lane_b(0, 9'h1FF, 4'b0001, 9'd21, 64'hBBBB);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("prio_ardy", 144'(a_ready), 144'(1'b1));
        chk("prio_brdy", 144'(b_ready), 144'(1'b0));
        exp_wr(0, 8'hFF, 9'd20, 64'hAAAA);
        exp_push();
        tick_check("prio");
        chk("prio_cnt", 144'(conflict_cnt), 144'(16'd1));
        chk("sb_empty", 144'(sb.size()), 144'(0));

        // saturation: inputs stay in conflict every cycle
        repeat (65533) @(posedge clk);
        #1;
        chk("sat_fffe", 144'(conflict_cnt), 144'(16'hFFFE));
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", 144'(conflict_cnt), 144'(16'hFFFF));

        @(negedge clk);
        clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
